// File: rtl/param_mem_pkg.sv
// Shared types and constants for the parametrised memory controller.
package param_mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_ACC_LATENCY = 2;
  localparam int MAX_ACC_LATENCY = 8;

  // Latency counter is wide enough for the largest legal ACC_LATENCY.
  localparam int LAT_W = $clog2(MAX_ACC_LATENCY) + 1;

  // Byte-lane merge of new data into an old word under a strobe mask.
  function automatic logic [DEF_WIDTH-1:0] merge_lanes(
    input logic [DEF_WIDTH-1:0]   old_word,
    input logic [DEF_WIDTH-1:0]   new_word,
    input logic [DEF_WIDTH/8-1:0] strb
  );
    logic [DEF_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < DEF_WIDTH/8; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/param_mem_array.sv
// Storage array: one byte-enabled write port, one asynchronous read port, no reset.
module param_mem_array
  import param_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [IW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write; callers only present in-range addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (wbe[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_mem_ctrl.sv
// Single-outstanding memory controller: post-reset clear, fixed access latency,
// byte strobes, out-of-range error and response backpressure.
module param_mem_ctrl
  import param_mem_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int ACC_LATENCY = DEF_ACC_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err,
  output logic                  init_done
);

  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BYTES = WIDTH / 8;

  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);
  localparam logic [LAT_W-1:0]    LAT_LOAD = LAT_W'(ACC_LATENCY - 1);

  state_t                  state_q,     state_d;
  logic [IW-1:0]           init_cnt_q,  init_cnt_d;
  logic [LAT_W-1:0]        lat_cnt_q,   lat_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic                    wr_rd_q,     wr_rd_d;
  logic [WIDTH-1:0]        wdata_q,     wdata_d;
  logic [BYTES-1:0]        wstrb_q,     wstrb_d;
  logic                    ready_q,     ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rdata_q,     rdata_d;
  logic                    err_q,       err_d;
  logic                    init_done_q, init_done_d;

  logic                    in_range_s;
  logic                    arr_we_s;
  logic [IW-1:0]           arr_waddr_s;
  logic [WIDTH-1:0]        arr_wdata_s;
  logic [BYTES-1:0]        arr_wbe_s;
  logic [WIDTH-1:0]        arr_rdata_s;

  assign in_range_s = ({1'b0, addr_q} < DEPTH_A);

  param_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .wbe   (arr_wbe_s),
    .raddr (addr_q[IW-1:0]),
    .rdata (arr_rdata_s)
  );

  // Next-state, array-port and response logic.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    wr_rd_d     = wr_rd_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    arr_we_s    = 1'b0;
    arr_waddr_s = init_cnt_q;
    arr_wdata_s = '0;
    arr_wbe_s   = '0;

    case (state_q)
      ST_INIT: begin
        arr_we_s    = 1'b1;
        arr_waddr_s = init_cnt_q;
        arr_wbe_s   = '1;
        if (init_cnt_q == LAST_IDX) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          ready_d     = 1'b1;
        end else begin
          init_cnt_d  = init_cnt_q + IW'(1);
        end
      end
      ST_IDLE: begin
        if (valid && ready_q) begin
          addr_d    = addr;
          wr_rd_d   = wr_rd;
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          lat_cnt_d = LAT_LOAD;
          ready_d   = 1'b0;
          state_d   = ST_WAIT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q != {LAT_W{1'b0}}) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
          // Write commits on the same edge the response is raised.
          if (!in_range_s) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (wr_rd_q) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = addr_q[IW-1:0];
            arr_wdata_s = wdata_q;
            arr_wbe_s   = wstrb_q;
            rdata_d     = '0;
            err_d       = 1'b0;
          end else begin
            rdata_d = arr_rdata_s;
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_cnt_d  = '0;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = '0;
        err_d       = 1'b0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      wr_rd_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      wr_rd_q     <= wr_rd_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  assign ready     = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Scoreboard bench for param_mem_ctrl (WIDTH=32, DEPTH=24, ACC_LATENCY=2).
module tb_param_mem_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int LAT   = 2;

  typedef struct {
    logic [WIDTH-1:0] rdata;
    logic             err;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             valid = 1'b0;
  logic             ready;
  logic             wr_rd = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [3:0]       wstrb = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic             init_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];

  param_mem_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ACC_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .wr_rd(wr_rd),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rdata(rdata), .err(err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each response is popped on the cycle it is accepted.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rdata, e.rdata);
        check("rsp_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request; hold keeps rsp_ready low that many cycles after rsp_valid.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_d,
                        input logic exp_e, input int hold);
    rsp_t e;
    int   cyc;
    wait_ready();
    rsp_ready = (hold == 0);
    valid = 1'b1; wr_rd = w; addr = a; wdata = d; wstrb = s;
    e.rdata = exp_d;
    e.err   = exp_e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0; wr_rd = ~w; addr = ~a; wdata = ~d; wstrb = ~s;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!rsp_valid && cyc < 20);
    check("rsp_latency", cyc, LAT);
    if (hold > 0) begin
      valid = 1'b1; wr_rd = 1'b1; addr = 5'd5; wdata = 32'h0; wstrb = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_rdata", rdata, exp_d);
        check("hold_err", {31'd0, err}, {31'd0, exp_e});
        check("hold_ready", {31'd0, ready}, 32'd0);
      end
      valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("rsp_done_rdata", rdata, 32'd0);
  endtask

  task automatic do_reset_init();
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      check("init_done_seq", {31'd0, init_done}, (k == DEPTH) ? 32'd1 : 32'd0);
      check("init_ready_seq", {31'd0, ready}, (k == DEPTH) ? 32'd1 : 32'd0);
    end
    n = 0;
    while (!init_done && n < 100) begin
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    // 1: reset, clear sequence, read of cleared location
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_init_done", {31'd0, init_done}, 32'd0);
    do_reset_init();
    do_req(1'b0, 5'd7, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    // 2-3: full write, read back, partial-strobe write, read back
    do_req(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    do_req(1'b0, 5'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b1, 5'd5, 32'h11223344, 4'b0101, 32'h0, 1'b0, 0);
    do_req(1'b0, 5'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);
    do_req(1'b1, 5'd5, 32'h55667788, 4'h0, 32'h0, 1'b0, 0);
    do_req(1'b0, 5'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);

    // 4: out-of-range accesses and the last legal location
    do_req(1'b1, 5'd30, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req(1'b0, 5'd30, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    do_req(1'b1, 5'd24, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req(1'b0, 5'd23, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    // 5: backpressure; the write offered while busy must be ignored
    do_req(1'b0, 5'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 5);
    do_req(1'b0, 5'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);

    // 6: reset in the middle of a write's wait phase
    wait_ready();
    valid = 1'b1; wr_rd = 1'b1; addr = 5'd5; wdata = 32'hAAAAAAAA; wstrb = 4'hF;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    check("async_rst_init_done", {31'd0, init_done}, 32'd0);
    do_reset_init();
    do_req(1'b0, 5'd5, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_mem_ctrl.md
Name: param_mem_ctrl

Overview:
- Parametrised single-port memory with a valid/ready request channel and a separate rsp_valid/rsp_ready response channel.
- Adds the following to the basic memory:
  - configurable data width, depth and address width
  - byte-lane write strobes
  - fixed programmable access latency
  - response backpressure
  - out-of-range error reporting
  - sequential post-reset clear
- Sits between a processor-side requester and on-chip storage. One transaction is outstanding at a time.

Parameters:
- WIDTH, 32, data bits per location; must be a multiple of 8.
- DEPTH, 32, number of locations; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address bits; must be >= $clog2(DEPTH).
- ACC_LATENCY, 2, cycles from request acceptance to response valid; legal range 1..8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  request valid.
- ready  output  1  request ready; handshake on edge where valid && ready.
- wr_rd  input  1  1 = write, 0 = read.
- addr  input  ADDR_WIDTH  location index.
- wdata  input  WIDTH  write data.
- wstrb  input  WIDTH/8  byte-lane write enables; ignored for reads.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted on edge where rsp_valid && rsp_ready.
- rdata  output  WIDTH  read data; 0 for write responses and for errors.
- err  output  1  set in a response when addr >= DEPTH.
- init_done  output  1  high once post-reset clear completes.

Behaviour:

Reset:
- rst low asynchronously forces ready=0, rsp_valid=0, rdata=0, err=0 and init_done=0, and puts the FSM in ST_INIT.
- Any in-flight transaction is dropped silently.
- The storage array has no reset.

FSM states: ST_INIT, ST_IDLE, ST_WAIT, ST_RESP.
- ST_INIT:
  - Clear counter writes 0 to location i on each cycle, for i = 0..DEPTH-1.
  - After the write to DEPTH-1, go to ST_IDLE and set init_done=1; it stays 1 until the next reset.
  - ready=0 throughout.
- ST_IDLE:
  - ready=1.
  - On valid && ready at edge T0: capture addr, wr_rd, wdata and wstrb; ready=0; load latency counter with ACC_LATENCY-1; go to ST_WAIT.
- ST_WAIT:
  - On each edge, decrement the counter while it is nonzero.
  - On the edge where the counter is 0 (edge T0+ACC_LATENCY), execute the access, drive rsp_valid=1 with rdata/err, and go to ST_RESP.
- ST_RESP:
  - rsp_valid, rdata and err are held stable until rsp_valid && rsp_ready at edge T1.
  - At T1: rsp_valid=0, rdata=0, err=0, go to ST_IDLE; ready=1 after T1.

Access semantics:
- Write with addr < DEPTH: lane b (bits 8b+7:8b) is updated only where wstrb[b]=1. The write commits on the same edge rsp_valid rises. rdata=0, err=0.
- Write with wstrb all zero: no change, normal response, err=0.
- Read with addr < DEPTH: rdata = array content at that edge, including the effect of all earlier responded writes.
- addr >= DEPTH: write suppressed, rdata=0, err=1.

Request rules:
- Requests while ready=0 are ignored, not queued. The requester holds valid and its payload until the handshake.
- Request fields change freely after acceptance; captured values are used.

Timing:
- Minimum spacing of back-to-back accepts is ACC_LATENCY+2 cycles, with rsp_ready held high.
- rsp_ready high before rsp_valid has no effect.

Decomposition:
- Package param_mem_pkg holds:
  - state_t enum (ST_INIT, ST_IDLE, ST_WAIT, ST_RESP)
  - default parameter constants
  - LAT_W = $clog2(8)+1 for the latency counter
- Sub-module param_mem_array holds the storage:
  - one write port with per-byte enables and one asynchronous read port
  - no reset
  - instantiated once; the clear sequence is driven through its write port.

Test Plan:

All scenarios use WIDTH=32, DEPTH=24, ADDR_WIDTH=5, ACC_LATENCY=2.
1. rst low 3 cycles then high -> init_done=0 and ready=0 for 24 cycles, then both 1. Read addr 7 -> rdata=0, err=0.
2. Write addr 5, wdata 0xDEADBEEF, wstrb 4'hF, then read addr 5 -> each rsp_valid rises exactly 2 edges after accept; read gives rdata=0xDEADBEEF, err=0.
3. Then write addr 5, wdata 0x11223344, wstrb 4'b0101, then read addr 5 -> rdata=0xDE22BE44.
4. Write addr 30, wdata 0xFFFFFFFF -> err=1. Read addr 30 -> err=1, rdata=0. Read addr 23 -> rdata=0, err=0.
5. Read addr 5 with rsp_ready low for 5 cycles -> rsp_valid, rdata=0xDE22BE44 and err held stable; ready=0 throughout; a new valid is ignored; handshake completes when rsp_ready rises.
6. Drive rst low mid-ST_WAIT of a write to addr 5 -> outputs reach reset values without a clock edge; no response is issued. After re-init, read addr 5 -> rdata=0.
